// File: rtl/ternary_dot_engine.sv
// ternary_dot_engine: streaming dot product of unsigned activations with ternary weights.
// Define TERNARY_DOT_SAT_EN for saturating accumulation with a sticky overflow flag.
module ternary_dot_engine #(
  parameter int unsigned IN_W  = 2,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 10,
  parameter int unsigned LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  input  logic [LANES*2-1:0]       w_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  result,
  output logic                     busy,
  output logic                     overflow
);

`ifdef TERNARY_DOT_SAT_EN
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] MAX_V = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {3'b111, {(ACC_W-1){1'b0}}};
`else
  // Wrapping only needs the low ACC_W bits of the lane sum.
  localparam int unsigned SUM_W = ACC_W;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                   state;
  logic [LEN_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [ACC_W-1:0]  acc_next;

  // Single-cycle adder tree over all lanes; weight 10 decodes as zero.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      case (w_data[2*k +: 2])
        2'b01:   lane_sum = lane_sum + SUM_W'(in_data[k*IN_W +: IN_W]);
        2'b11:   lane_sum = lane_sum - SUM_W'(in_data[k*IN_W +: IN_W]);
        default: lane_sum = lane_sum;
      endcase
    end
  end

`ifdef TERNARY_DOT_SAT_EN
  logic signed [EXT_W-1:0] acc_sum;
  logic                    sat_hit;
  logic                    ovf_q;

  assign acc_sum = {{2{acc[ACC_W-1]}}, acc} + {lane_sum[SUM_W-1], lane_sum};

  always_comb begin
    acc_next = acc_sum[ACC_W-1:0];
    sat_hit  = 1'b0;
    if (acc_sum > MAX_V) begin
      acc_next = MAX_V[ACC_W-1:0];
      sat_hit  = 1'b1;
    end else if (acc_sum < MIN_V) begin
      acc_next = MIN_V[ACC_W-1:0];
      sat_hit  = 1'b1;
    end
  end

  // Sticky for the whole operation; cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state == ACCUM && in_valid && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign acc_next = acc + lane_sum;
  assign overflow = 1'b0;
`endif

  assign result = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc  <= '0;
            busy <= 1'b1;
            if (len != '0) begin
              cnt      <= len;
              in_ready <= 1'b1;
              state    <= ACCUM;
            end else begin
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            cnt <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ternary_dot_engine.md
TERNARY_DOT_ENGINE -- requirements
Module: ternary_dot_engine

Interface
REQ-001 SHALL have parameter IN_W, default 2, unsigned activation width per lane (1..8).
REQ-002 SHALL have parameter LANES, default 4, number of parallel ternary MAC lanes (1..16).
REQ-003 SHALL have parameter ACC_W, default 10, signed accumulator and result width (>= IN_W+3).
REQ-004 SHALL have parameter LEN_W, default 4, width of the beat-count field.
REQ-005 SHALL have the port clk, input, 1, clock; all state changes on its rising edge.
REQ-006 SHALL have the port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have the port start, input, 1, begin a dot product; sampled in IDLE only.
REQ-008 SHALL have the port len, input, LEN_W, number of beats; sampled with start.
REQ-009 SHALL have the ports in_valid (input, 1) and in_ready (output, 1), beat handshake.
REQ-010 SHALL have the port in_data, input, LANES*IN_W, unsigned activations; lane k at bits [k*IN_W +: IN_W].
REQ-011 SHALL have the port w_data, input, LANES*2, ternary weights; lane k at bits [2k +: 2].
REQ-012 SHALL have the ports out_valid (output, 1) and out_ready (input, 1), result handshake.
REQ-013 SHALL have the port result, output, ACC_W, signed dot product.
REQ-014 SHALL have the ports busy (output, 1), high outside IDLE, and overflow (output, 1), sticky saturation flag.

Function
REQ-015 SHALL decode each weight as 00=0, 01=+1, 11=-1, 10=0.
REQ-016 SHALL form each lane product as zero-extended activation times the decoded weight, then sum all lanes in one cycle, sign-extended to ACC_W+1 bits.
REQ-017 SHALL implement the states IDLE, ACCUM and HOLD.
REQ-018 IDLE: when start=1 and len!=0, SHALL clear the accumulator, load the beat counter with len, and go to ACCUM.
REQ-019 IDLE: when start=1 and len=0, SHALL clear the accumulator and go directly to HOLD with result 0.
REQ-020 in_ready SHALL be 1 only in ACCUM, combinationally independent of in_valid.
REQ-021 ACCUM: each cycle with in_valid=1 SHALL add the lane sum to the accumulator and decrement the counter; a cycle with in_valid=0 SHALL change nothing.
REQ-022 ACCUM: on the beat that decrements the counter from 1, SHALL go to HOLD; out_valid SHALL be 1 in the following cycle, giving a latency of 1 cycle from the last beat.
REQ-023 HOLD: out_valid=1 and result SHALL stay stable until out_ready=1; on that cycle SHALL go to IDLE.
REQ-024 start SHALL be ignored in ACCUM and HOLD; after a HOLD->IDLE handshake, start SHALL be accepted the next cycle.
REQ-025 result SHALL always equal the accumulator register; overflow SHALL clear on each accepted start.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, accumulator 0, counter 0, result 0, out_valid 0, in_ready 0, busy 0 and overflow 0, including mid-operation.
REQ-027 The first accepted start SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With macro TERNARY_DOT_SAT_EN defined, each accumulate SHALL clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set overflow when clamping occurs.
REQ-029 Without TERNARY_DOT_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and overflow SHALL be tied to 0.

Verification
REQ-030 Defaults: start, len=3; beats {in=3,3,3,3; w=+1 all}, {in=1,2,3,0; w=-1,+1,0,10}, {in=2 all; w=-1 all} -> out_valid one cycle after the 3rd beat, result=12+1-8=5.
REQ-031 len=0 start -> busy for 1 cycle, out_valid with result=0, no in_ready.
REQ-032 in_valid gaps between beats, and out_ready held low for 5 cycles -> result unchanged, out_valid held, start during HOLD ignored.
REQ-033 ACC_W=6, SAT_EN defined: 4 beats of in=3, w=+1, LANES=4 (+12 each) -> result=31, overflow=1; without the macro -> result=-16 (48 mod 64), overflow=0.
REQ-034 rst_n pulsed low mid-ACCUM -> all outputs 0 asynchronously; a fresh start then computes correctly.
